// File: rtl/mem_arbiter_if.sv
// Memory request/response port: valid/ready request channel carrying address
// and optional write data, plus a valid/ready response channel.
// master = the side issuing requests, slave = the side serving them.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  SEND_ADDR_VALID;
    logic [DATA_WIDTH-1:0] SEND_ADDR;
    logic                  SEND_DATA_VALID;
    logic [DATA_WIDTH-1:0] SEND_DATA;
    logic                  SEND_READY;
    logic                  RECEIVE_VALID;
    logic [DATA_WIDTH-1:0] RECEIVE_DATA;
    logic                  RECEIVE_READY;

    modport master (
        output SEND_ADDR_VALID, SEND_ADDR, SEND_DATA_VALID, SEND_DATA, RECEIVE_READY,
        input  SEND_READY, RECEIVE_VALID, RECEIVE_DATA
    );

    modport slave (
        input  SEND_ADDR_VALID, SEND_ADDR, SEND_DATA_VALID, SEND_DATA, RECEIVE_READY,
        output SEND_READY, RECEIVE_VALID, RECEIVE_DATA
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a single memory port.
// One transaction is outstanding at a time; the grant is held from the
// request phase through the response (or the send handshake for
// unacknowledged writes). Client 0 is the packet loader, client 1 the
// memory accessor.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter bit WRITE_ACK  = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  c0,
    mem_arbiter_if.slave  c1,
    mem_arbiter_if.master mem,
    output logic [1:0]    GRANT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_grant;
    logic       r_last;

    logic                  w_sel;
    logic                  w_in_send;
    logic                  w_in_wait;
    logic                  w_req_addr_valid;
    logic [DATA_WIDTH-1:0] w_req_addr;
    logic                  w_req_data_valid;
    logic [DATA_WIDTH-1:0] w_req_data;
    logic                  w_req_recv_ready;
    logic                  w_send_hs;
    logic                  w_recv_hs;

    // r_grant is one-hot whenever a transaction is active, so bit 1 is the index
    assign w_sel     = r_grant[1];
    assign w_in_send = (r_state == S_SEND);
    assign w_in_wait = (r_state == S_WAIT);

    // Select the granted client's request and response-ready signals
    always_comb begin
        w_req_addr_valid = w_sel ? c1.SEND_ADDR_VALID : c0.SEND_ADDR_VALID;
        w_req_addr       = w_sel ? c1.SEND_ADDR       : c0.SEND_ADDR;
        w_req_data_valid = w_sel ? c1.SEND_DATA_VALID : c0.SEND_DATA_VALID;
        w_req_data       = w_sel ? c1.SEND_DATA       : c0.SEND_DATA;
        w_req_recv_ready = w_sel ? c1.RECEIVE_READY   : c0.RECEIVE_READY;
    end

    assign w_send_hs = w_in_send & w_req_addr_valid & mem.SEND_READY;
    assign w_recv_hs = w_in_wait & mem.RECEIVE_VALID & w_req_recv_ready;

    // Memory-side outputs: request only forwarded in S_SEND, response only accepted in S_WAIT
    always_comb begin
        mem.SEND_ADDR_VALID = w_in_send & w_req_addr_valid;
        mem.SEND_ADDR       = w_in_send ? w_req_addr : '0;
        mem.SEND_DATA_VALID = w_in_send & w_req_data_valid;
        mem.SEND_DATA       = w_in_send ? w_req_data : '0;
        mem.RECEIVE_READY   = w_in_wait & w_req_recv_ready;
    end

    // Client-side outputs: only the granted client ever sees ready/valid
    always_comb begin
        c0.SEND_READY    = w_in_send & r_grant[0] & mem.SEND_READY;
        c1.SEND_READY    = w_in_send & r_grant[1] & mem.SEND_READY;
        c0.RECEIVE_VALID = w_in_wait & r_grant[0] & mem.RECEIVE_VALID;
        c1.RECEIVE_VALID = w_in_wait & r_grant[1] & mem.RECEIVE_VALID;
        c0.RECEIVE_DATA  = mem.RECEIVE_DATA;
        c1.RECEIVE_DATA  = mem.RECEIVE_DATA;
    end

    assign GRANT = r_grant;

    // Arbitration FSM: pick a client in idle, hold the grant until completion
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (c0.SEND_ADDR_VALID && c1.SEND_ADDR_VALID) begin
                        // Tie: the client that did not complete last goes next
                        r_grant <= r_last ? 2'b01 : 2'b10;
                        r_state <= S_SEND;
                    end else if (c0.SEND_ADDR_VALID) begin
                        r_grant <= 2'b01;
                        r_state <= S_SEND;
                    end else if (c1.SEND_ADDR_VALID) begin
                        r_grant <= 2'b10;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_send_hs) begin
                        if (w_req_data_valid && !WRITE_ACK) begin
                            // Posted write: done as soon as memory takes it
                            r_state <= S_IDLE;
                            r_last  <= w_sel;
                            r_grant <= 2'b00;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_recv_hs) begin
                        r_state <= S_IDLE;
                        r_last  <= w_sel;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WRITE_ACK = 0). Inputs change 1 ns after
// the rising edge; outputs are checked 2 ns after the edge.
module tb_mem_arbiter;

    logic CLK = 1'b0;
    logic RST;
    logic [1:0] GRANT;

    int total = 0;
    int bad   = 0;

    mem_arbiter_if #(.DATA_WIDTH(32)) c0  ();
    mem_arbiter_if #(.DATA_WIDTH(32)) c1  ();
    mem_arbiter_if #(.DATA_WIDTH(32)) mem ();

    mem_arbiter #(.DATA_WIDTH(32), .WRITE_ACK(1'b0)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .c0    (c0),
        .c1    (c1),
        .mem   (mem),
        .GRANT (GRANT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        c0.SEND_ADDR_VALID = 0; c0.SEND_ADDR = '0; c0.SEND_DATA_VALID = 0; c0.SEND_DATA = '0; c0.RECEIVE_READY = 0;
        c1.SEND_ADDR_VALID = 0; c1.SEND_ADDR = '0; c1.SEND_DATA_VALID = 0; c1.SEND_DATA = '0; c1.RECEIVE_READY = 0;
        mem.SEND_READY = 0; mem.RECEIVE_VALID = 0; mem.RECEIVE_DATA = '0;

        // ---- reset state ----
        step(); step(); #1;
        chk("rst_grant", {30'd0, GRANT}, 32'd0);
        chk("rst_mem_av", {31'd0, mem.SEND_ADDR_VALID}, 32'd0);
        chk("rst_mem_addr", mem.SEND_ADDR, 32'd0);
        chk("rst_mem_rr", {31'd0, mem.RECEIVE_READY}, 32'd0);
        RST = 1'b0;

        // ---- single read from C0 ----
        step();
        c0.SEND_ADDR_VALID = 1; c0.SEND_ADDR = 32'h40; c0.RECEIVE_READY = 1;
        mem.SEND_READY = 1;
        #1;
        chk("t1_idle_grant", {30'd0, GRANT}, 32'd0);
        chk("t1_idle_mem_av", {31'd0, mem.SEND_ADDR_VALID}, 32'd0);
        step(); #1;
        chk("t1_grant", {30'd0, GRANT}, 32'h1);
        chk("t1_mem_av", {31'd0, mem.SEND_ADDR_VALID}, 32'd1);
        chk("t1_mem_addr", mem.SEND_ADDR, 32'h40);
        chk("t1_mem_dv", {31'd0, mem.SEND_DATA_VALID}, 32'd0);
        chk("t1_c0_sr", {31'd0, c0.SEND_READY}, 32'd1);
        chk("t1_c1_sr", {31'd0, c1.SEND_READY}, 32'd0);
        step();
        c0.SEND_ADDR_VALID = 0;
        mem.RECEIVE_VALID = 1; mem.RECEIVE_DATA = 32'hDEADBEEF;
        #1;
        chk("t1_c0_rv", {31'd0, c0.RECEIVE_VALID}, 32'd1);
        chk("t1_c0_rd", c0.RECEIVE_DATA, 32'hDEADBEEF);
        chk("t1_mem_rr", {31'd0, mem.RECEIVE_READY}, 32'd1);
        chk("t1_c1_rv", {31'd0, c1.RECEIVE_VALID}, 32'd0);
        chk("t1_wait_mem_av", {31'd0, mem.SEND_ADDR_VALID}, 32'd0);
        step();
        mem.RECEIVE_VALID = 0;
        #1;
        chk("t1_done_grant", {30'd0, GRANT}, 32'd0);
        $display("txn: C0 read 0x40 -> 0xDEADBEEF");

        // ---- simultaneous requests after reset ----
        RST = 1'b1;
        step();
        RST = 1'b0;
        c0.SEND_ADDR_VALID = 1; c0.SEND_ADDR = 32'h10;
        c1.SEND_ADDR_VALID = 1; c1.SEND_ADDR = 32'h20; c1.RECEIVE_READY = 1;
        step(); #1;
        chk("t2_tie_grant", {30'd0, GRANT}, 32'h1);
        chk("t2_tie_addr", mem.SEND_ADDR, 32'h10);
        chk("t2_c1_sr", {31'd0, c1.SEND_READY}, 32'd0);
        step();
        c0.SEND_ADDR_VALID = 0;
        mem.RECEIVE_VALID = 1; mem.RECEIVE_DATA = 32'h111;
        #1;
        chk("t2_c0_rv", {31'd0, c0.RECEIVE_VALID}, 32'd1);
        chk("t2_c1_rv", {31'd0, c1.RECEIVE_VALID}, 32'd0);
        step();   // response handshake at u
        mem.RECEIVE_VALID = 0;
        #1;
        chk("t2_u1_grant", {30'd0, GRANT}, 32'd0);
        step(); #1;   // u+2
        chk("t2_u2_grant", {30'd0, GRANT}, 32'h2);
        chk("t2_u2_addr", mem.SEND_ADDR, 32'h20);
        $display("txn: C0 read 0x10 served, C1 granted");
        c0.SEND_ADDR_VALID = 1; c0.SEND_ADDR = 32'h30;   // arrives mid-transaction
        step();
        c1.SEND_ADDR_VALID = 0;
        mem.RECEIVE_VALID = 1; mem.RECEIVE_DATA = 32'h222;
        #1;
        chk("t2_c1_rv", {31'd0, c1.RECEIVE_VALID}, 32'd1);
        chk("t2_c1_rd", c1.RECEIVE_DATA, 32'h222);
        chk("t2_c0_rv_off", {31'd0, c0.RECEIVE_VALID}, 32'd0);
        chk("t2_c0_sr_off", {31'd0, c0.SEND_READY}, 32'd0);
        step();
        mem.RECEIVE_VALID = 0;
        c1.SEND_ADDR_VALID = 1; c1.SEND_ADDR = 32'h24;
        #1;
        chk("t2_idle_grant", {30'd0, GRANT}, 32'd0);
        step(); #1;
        chk("t2_retie_grant", {30'd0, GRANT}, 32'h1);
        chk("t2_retie_addr", mem.SEND_ADDR, 32'h30);
        step();
        c0.SEND_ADDR_VALID = 0;
        mem.RECEIVE_VALID = 1; mem.RECEIVE_DATA = 32'h333;
        step();
        mem.RECEIVE_VALID = 0;
        step(); #1;
        chk("t2_c1_again_grant", {30'd0, GRANT}, 32'h2);
        chk("t2_c1_again_addr", mem.SEND_ADDR, 32'h24);
        step();
        c1.SEND_ADDR_VALID = 0;
        mem.RECEIVE_VALID = 1; mem.RECEIVE_DATA = 32'h444;
        step();
        mem.RECEIVE_VALID = 0;
        $display("txn: C0 read 0x30 and C1 read 0x24 alternated");

        // ---- C1 posted write, concurrent C0 read ----
        c1.SEND_ADDR_VALID = 1; c1.SEND_ADDR = 32'h8; c1.SEND_DATA_VALID = 1; c1.SEND_DATA = 32'h55;
        step();
        c0.SEND_ADDR_VALID = 1; c0.SEND_ADDR = 32'h44;
        #1;
        chk("t3_grant", {30'd0, GRANT}, 32'h2);
        chk("t3_mem_dv", {31'd0, mem.SEND_DATA_VALID}, 32'd1);
        chk("t3_mem_data", mem.SEND_DATA, 32'h55);
        chk("t3_mem_addr", mem.SEND_ADDR, 32'h8);
        chk("t3_c0_sr", {31'd0, c0.SEND_READY}, 32'd0);
        step();
        c1.SEND_ADDR_VALID = 0; c1.SEND_DATA_VALID = 0;
        #1;
        chk("t3_done_grant", {30'd0, GRANT}, 32'd0);
        chk("t3_mem_rr", {31'd0, mem.RECEIVE_READY}, 32'd0);
        step();
        mem.SEND_READY = 0;
        #1;
        chk("t3_c0_next", {30'd0, GRANT}, 32'h1);
        chk("t3_c0_addr", mem.SEND_ADDR, 32'h44);
        $display("txn: C1 write 0x8=0x55 posted, C0 granted next");

        // ---- stalls ----
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk($sformatf("t4_ss_grant%0d", i), {30'd0, GRANT}, 32'h1);
            chk($sformatf("t4_ss_addr%0d", i), mem.SEND_ADDR, 32'h44);
            chk($sformatf("t4_ss_av%0d", i), {31'd0, mem.SEND_ADDR_VALID}, 32'd1);
            chk($sformatf("t4_ss_sr%0d", i), {31'd0, c0.SEND_READY}, 32'd0);
        end
        mem.SEND_READY = 1;
        #1;
        chk("t4_sr_up", {31'd0, c0.SEND_READY}, 32'd1);
        step();
        c0.SEND_ADDR_VALID = 0; c0.RECEIVE_READY = 0;
        mem.RECEIVE_VALID = 1; mem.RECEIVE_DATA = 32'hABCD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_rs_rv%0d", i), {31'd0, c0.RECEIVE_VALID}, 32'd1);
            chk($sformatf("t4_rs_rr%0d", i), {31'd0, mem.RECEIVE_READY}, 32'd0);
            chk($sformatf("t4_rs_grant%0d", i), {30'd0, GRANT}, 32'h1);
            step();
        end
        c0.RECEIVE_READY = 1;
        #1;
        chk("t4_rr_up", {31'd0, mem.RECEIVE_READY}, 32'd1);
        chk("t4_rd", c0.RECEIVE_DATA, 32'hABCD);
        step(); #1;   // memory keeps RECEIVE_VALID high: now unsolicited
        chk("t4_done_grant", {30'd0, GRANT}, 32'd0);
        chk("t4_no_second_rv", {31'd0, c0.RECEIVE_VALID}, 32'd0);
        $display("txn: C0 read 0x44 through send and receive stalls");

        // ---- unsolicited response ----
        chk("t5_mem_rr", {31'd0, mem.RECEIVE_READY}, 32'd0);
        chk("t5_c1_rv", {31'd0, c1.RECEIVE_VALID}, 32'd0);
        step(); #1;
        chk("t5_grant", {30'd0, GRANT}, 32'd0);
        chk("t5_c0_rv", {31'd0, c0.RECEIVE_VALID}, 32'd0);
        mem.RECEIVE_VALID = 0;
        $display("txn: unsolicited response ignored");

        // ---- reset mid-operation ----
        c1.SEND_ADDR_VALID = 1; c1.SEND_ADDR = 32'h60; c1.RECEIVE_READY = 0;
        step(); #1;
        chk("t6_grant", {30'd0, GRANT}, 32'h2);
        step();
        c1.SEND_ADDR_VALID = 0;
        mem.RECEIVE_VALID = 1; mem.RECEIVE_DATA = 32'h666;
        #1;
        chk("t6_wait_rv", {31'd0, c1.RECEIVE_VALID}, 32'd1);
        RST = 1'b1;
        step(); #1;
        chk("t6_rst_grant", {30'd0, GRANT}, 32'd0);
        chk("t6_rst_c1_rv", {31'd0, c1.RECEIVE_VALID}, 32'd0);
        chk("t6_rst_mem_rr", {31'd0, mem.RECEIVE_READY}, 32'd0);
        chk("t6_rst_mem_av", {31'd0, mem.SEND_ADDR_VALID}, 32'd0);
        RST = 1'b0;
        mem.RECEIVE_VALID = 0;
        c0.SEND_ADDR_VALID = 1; c0.SEND_ADDR = 32'h70;
        c1.SEND_ADDR_VALID = 1; c1.SEND_ADDR = 32'h74;
        step(); #1;
        chk("t6_tie_grant", {30'd0, GRANT}, 32'h1);
        chk("t6_tie_addr", mem.SEND_ADDR, 32'h70);
        $display("txn: reset in S_WAIT, tie then goes to C0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter that shares the single memory port between the packet loader (client 0) and the memory accessor (client 1). Each client sees the same valid/ready address, data and response interface it would see if directly attached to memory. The arbiter grants one transaction at a time round-robin and holds the grant until the transaction completes, so exactly one transaction is outstanding at memory. Sits between the two clients and the cache/memory interface.

## Interface
- DATA_WIDTH, 32, width of address, write data and response data.
- WRITE_ACK, 0: 0 = a write completes on its send handshake; 1 = a write also waits for one response word.
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- Cn_SEND_ADDR_VALID  in  1  client n (n = 0, 1) request valid.
- Cn_SEND_ADDR  in  DATA_WIDTH  client n address.
- Cn_SEND_DATA_VALID  in  1  client n write qualifier; high with ADDR_VALID means write.
- Cn_SEND_DATA  in  DATA_WIDTH  client n write data.
- Cn_SEND_READY  out  1  client n request accepted.
- Cn_RECEIVE_VALID  out  1  response valid to client n.
- Cn_RECEIVE_DATA  out  DATA_WIDTH  response data; always equals MEM_RECEIVE_DATA.
- Cn_RECEIVE_READY  in  1  client n can take the response.
- MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA  out  1/DATA_WIDTH/1/DATA_WIDTH  memory request.
- MEM_SEND_READY  in  1  memory accepts the request.
- MEM_RECEIVE_VALID  in  1  memory response valid.
- MEM_RECEIVE_DATA  in  DATA_WIDTH  memory response data.
- MEM_RECEIVE_READY  out  1  arbiter accepts the response.
- GRANT  out  2  one-hot current grant; 2'b00 when idle.

## Operation
- The state machine is in one of three states: S_IDLE, S_SEND, S_WAIT. A registered one-hot `grant` and a registered `last` (index of the most recently completed client) qualify it.
- **S_IDLE**
  - If a Cn_SEND_ADDR_VALID is high, register `grant` and go to S_SEND.
  - If only one client requests, that client wins.
  - If both request, the client other than `last` wins.
  - `last` resets to 1, so client 0 wins the first tie.
- **S_SEND**
  - MEM_SEND_* is a combinational mux of the granted client's SEND_* signals.
  - The granted client's SEND_READY = MEM_SEND_READY.
  - On the handshake MEM_SEND_ADDR_VALID && MEM_SEND_READY:
    - read (DATA_VALID = 0), or write with WRITE_ACK = 1: go to S_WAIT.
    - write with WRITE_ACK = 0: go to S_IDLE, set `last` = granted index, clear `grant`.
- **S_WAIT**
  - The granted client's RECEIVE_VALID = MEM_RECEIVE_VALID.
  - MEM_RECEIVE_READY = the granted client's RECEIVE_READY.
  - On the handshake, go to S_IDLE, update `last`, clear `grant`.
- **Ungranted client, any state:** SEND_READY = 0 and RECEIVE_VALID = 0.
- **Outside S_SEND:** MEM_SEND_ADDR_VALID = 0, MEM_SEND_DATA_VALID = 0, MEM_SEND_ADDR = 0, MEM_SEND_DATA = 0.
- **Outside S_WAIT:** MEM_RECEIVE_READY = 0. Unsolicited responses are not consumed.
- **Client protocol:** a client holds ADDR_VALID, ADDR, DATA_VALID and DATA stable from assertion until its handshake. A request from the losing client stays pending and is granted in the next S_IDLE.

## Timing
- **Reset values:** all outputs 0 (GRANT = 0, all VALID/READY = 0, MEM_SEND_ADDR = 0). State is S_IDLE, `last` = 1.
- **Reset mid-transaction:** abandon the transaction immediately; return to the reset values on the next cycle. A memory response still in flight is not tracked.
- **Grant latency:** a request seen in S_IDLE at cycle t gives GRANT and MEM_SEND_ADDR_VALID at cycle t+1. The earliest send handshake is t+1; the earliest response acceptance is t+2.
- **Turnaround:** after a completing handshake at cycle u, the state is S_IDLE at u+1 and the next grant appears at u+2. A client that completes at u and re-requests is re-granted at u+2 only if the other client is idle.
- **Mid-transaction requests:** the other client's request arriving during S_SEND or S_WAIT is not sampled until S_IDLE.
- **Fairness:** with both clients requesting continuously, grants alternate 0, 1, 0, 1, and neither client waits more than one transaction.
- **Stalls:** MEM_SEND_READY or RECEIVE_READY held low stalls in S_SEND or S_WAIT indefinitely, with no timeout. Grant and muxed signals stay constant during the stall.

## Test plan
- **Single read from C0:** C0 read at addr 0x40, memory ready, response 0xDEADBEEF one cycle later -> GRANT = 01 at t+1, MEM_SEND_ADDR = 0x40 at t+1, C0_RECEIVE_VALID with 0xDEADBEEF, C1 signals stay 0.
- **Simultaneous requests after reset:** C0 read 0x10 and C1 read 0x20 both asserted -> C0 served first, then C1 granted exactly 2 cycles after C0's response handshake. A repeat tie afterwards goes to C0 (alternation).
- **Write, WRITE_ACK = 0:** C1 write addr 0x8, data 0x55 -> MEM_SEND_DATA_VALID = 1 with data 0x55, no S_WAIT, GRANT = 00 the cycle after the send handshake. A concurrent C0 read is granted next.
- **Stalls:** MEM_SEND_READY low 5 cycles, then C0 RECEIVE_READY low 3 cycles -> grant and all muxed values stable throughout. MEM_RECEIVE_READY stays 0 until C0 is ready; exactly one response is delivered.
- **Unsolicited response:** MEM_RECEIVE_VALID pulsed while in S_IDLE -> MEM_RECEIVE_READY = 0, no client RECEIVE_VALID.
- **Reset mid-operation:** RST asserted in S_WAIT -> next cycle all outputs 0, GRANT = 00. After reset, a tie between clients goes to C0.
